// File: rtl/sym_sched.sv
// sym_sched: two-requester round-robin symbol scheduler in front of an
// external FSM.
//
// The granted requester streams 2-bit symbols onto the registered {x1,x0}
// outputs, one per cycle. The FSM's {z1,z0} response is captured two cycles
// after each accept and is tagged with the id of the requester that owned
// that symbol.
//
// Optional feature: define SYM_SCHED_TIMEOUT_EN to build the burst-stall
// timeout. When the granted requester's val has been low for 7 consecutive
// BURST cycles and is still low, the grant is released and err pulses for
// one cycle. Without the macro, err is tied low and the grant is held
// indefinitely.
module sym_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       val0,
  input  logic [1:0] sym0,
  input  logic       last0,
  output logic       rdy0,
  input  logic       val1,
  input  logic [1:0] sym1,
  input  logic       last1,
  output logic       rdy1,
  output logic       x1,
  output logic       x0,
  input  logic [1:0] z_in,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [1:0] rsp_z,
  output logic       busy,
  output logic       err
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_gnt_q, last_gnt_d;

  logic       val_g;
  logic [1:0] sym_g;
  logic       last_g;
  logic       acc;
  logic       timeout;

  logic [1:0] x_q;
  logic       vld_p0_q, id_p0_q;
  logic       vld_p1_q, id_p1_q;
  logic       rsp_valid_q, rsp_id_q;
  logic [1:0] rsp_z_q;

  // Only the granted requester's signals are looked at; the other side is ignored.
  assign val_g  = gnt_q ? val1  : val0;
  assign sym_g  = gnt_q ? sym1  : sym0;
  assign last_g = gnt_q ? last1 : last0;
  assign acc    = (state_q == BURST) && val_g;

  assign rdy0 = (state_q == BURST) && !gnt_q;
  assign rdy1 = (state_q == BURST) && gnt_q;
  assign busy = (state_q == BURST);

`ifdef SYM_SCHED_TIMEOUT_EN
  logic [2:0] cnt_q, cnt_d;
  logic       err_q;

  assign timeout = (state_q == BURST) && !val_g && (cnt_q == 3'd7);
  assign err     = err_q;

  // Count consecutive stalled BURST cycles; any accept or leaving BURST clears it.
  always_comb begin
    cnt_d = 3'd0;
    if ((state_q == BURST) && !acc) cnt_d = cnt_q + 3'd1;
  end

  // Stall counter and the one-cycle timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 3'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Next-state logic: round-robin grant in IDLE, burst end on last symbol or timeout.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    if (state_q == IDLE) begin
      if (val0 || val1) begin
        state_d = BURST;
        gnt_d   = (val0 && val1) ? ~last_gnt_q : val1;
      end
    end else begin
      if ((acc && last_g) || timeout) begin
        state_d    = IDLE;
        last_gnt_d = gnt_q;
      end
    end
  end

  // State register; last_gnt resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Symbol issue (p0), id delay (p1), response capture two edges after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= 2'b00;
      vld_p0_q    <= 1'b0;
      id_p0_q     <= 1'b0;
      vld_p1_q    <= 1'b0;
      id_p1_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_z_q     <= 2'b00;
    end else begin
      x_q         <= acc ? sym_g : 2'b00;
      vld_p0_q    <= acc;
      id_p0_q     <= gnt_q;
      vld_p1_q    <= vld_p0_q;
      id_p1_q     <= id_p0_q;
      rsp_valid_q <= vld_p1_q;
      rsp_id_q    <= id_p1_q;
      if (vld_p1_q) rsp_z_q <= z_in;
    end
  end

  assign x1        = x_q[1];
  assign x0        = x_q[0];
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_sym_sched.sv
// Directed testbench for sym_sched. The external FSM is modelled as a Moore
// machine whose output is the previous cycle's x with its bits swapped, so
// each rsp_z should equal the swapped symbol that was accepted.
module tb_sym_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       val0 = 1'b0, last0 = 1'b0, val1 = 1'b0, last1 = 1'b0;
  logic [1:0] sym0 = 2'b00, sym1 = 2'b00;
  logic       rdy0, rdy1, x1, x0, rsp_valid, rsp_id, busy, err;
  logic [1:0] rsp_z;
  logic [1:0] zq = 2'b00;
  logic [1:0] xv;

  int checks = 0;
  int errors = 0;

  sym_sched dut (
    .clk(clk), .rst(rst),
    .val0(val0), .sym0(sym0), .last0(last0), .rdy0(rdy0),
    .val1(val1), .sym1(sym1), .last1(last1), .rdy1(rdy1),
    .x1(x1), .x0(x0), .z_in(zq),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  assign xv = {x1, x0};

  // External FSM model: z is last cycle's x, bits swapped.
  always @(posedge clk) zq <= {x0, x1};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy0"},  8'(rdy0), 8'd0);
    chk({tag, "_rdy1"},  8'(rdy1), 8'd0);
    chk({tag, "_x"},     8'(xv), 8'd0);
    chk({tag, "_rspv"},  8'(rsp_valid), 8'd0);
    chk({tag, "_rspid"}, 8'(rsp_id), 8'd0);
    chk({tag, "_rspz"},  8'(rsp_z), 8'd0);
    chk({tag, "_busy"},  8'(busy), 8'd0);
    chk({tag, "_err"},   8'(err), 8'd0);
  endtask

  initial begin
    tick; tick;
    chk_reset("rst0");
    rst = 1'b0;

    // A: three-symbol burst from requester 0
    val0 = 1'b1; sym0 = 2'b01; last0 = 1'b0;
    tick;
    chk("A_busy", 8'(busy), 8'd1);
    chk("A_rdy0", 8'(rdy0), 8'd1);
    chk("A_rdy1", 8'(rdy1), 8'd0);
    chk("A_x_pre", 8'(xv), 8'd0);
    tick;
    chk("A_x1", 8'(xv), 8'b01);
    sym0 = 2'b10;
    tick;
    chk("A_x2", 8'(xv), 8'b10);
    chk("A_norsp", 8'(rsp_valid), 8'd0);
    sym0 = 2'b11; last0 = 1'b1;
    tick;
    chk("A_x3", 8'(xv), 8'b11);
    chk("A_rspv1", 8'(rsp_valid), 8'd1);
    chk("A_rspid1", 8'(rsp_id), 8'd0);
    chk("A_rspz1", 8'(rsp_z), 8'b10);
    chk("A_busy_end", 8'(busy), 8'd0);
    chk("A_rdy0_end", 8'(rdy0), 8'd0);
    val0 = 1'b0; last0 = 1'b0;
    tick;
    chk("A_x_idle", 8'(xv), 8'd0);
    chk("A_rspv2", 8'(rsp_valid), 8'd1);
    chk("A_rspz2", 8'(rsp_z), 8'b01);
    tick;
    chk("A_rspv3", 8'(rsp_valid), 8'd1);
    chk("A_rspid3", 8'(rsp_id), 8'd0);
    chk("A_rspz3", 8'(rsp_z), 8'b11);
    tick;
    chk("A_rspv_off", 8'(rsp_valid), 8'd0);

    // B: after reset, both requesters send single-symbol bursts
    rst = 1'b1;
    tick;
    rst = 1'b0;
    val0 = 1'b1; val1 = 1'b1; last0 = 1'b1; last1 = 1'b1;
    sym0 = 2'b01; sym1 = 2'b10;
    for (int g = 0; g < 4; g++) begin
      tick;
      chk("B_rdy0", 8'(g % 2 == 0), 8'(rdy0));
      chk("B_rdy1", 8'(rdy1), 8'(g % 2 == 1));
      chk("B_busy", 8'(busy), 8'd1);
      tick;
      chk("B_idle", 8'(busy), 8'd0);
      chk("B_x", 8'(xv), (g % 2 == 1) ? 8'b10 : 8'b01);
      if (g > 0) begin
        chk("B_rspv", 8'(rsp_valid), 8'd1);
        chk("B_rspid", 8'(rsp_id), 8'((g - 1) % 2));
        chk("B_rspz", 8'(rsp_z), ((g - 1) % 2 == 1) ? 8'b01 : 8'b10);
      end
    end
    val0 = 1'b0; val1 = 1'b0;
    tick; tick; tick;

    // C: burst from requester 1, then immediately from requester 0
    val1 = 1'b1; sym1 = 2'b01; last1 = 1'b1;
    tick;
    chk("C_rdy1", 8'(rdy1), 8'd1);
    chk("C_rdy0", 8'(rdy0), 8'd0);
    val0 = 1'b1; sym0 = 2'b11; last0 = 1'b1;
    chk("C_ungr_rdy0", 8'(rdy0), 8'd0);
    tick;
    chk("C_x1", 8'(xv), 8'b01);
    chk("C_idle", 8'(busy), 8'd0);
    val1 = 1'b0;
    tick;
    chk("C_rdy0_g", 8'(rdy0), 8'd1);
    chk("C_rdy1_g", 8'(rdy1), 8'd0);
    tick;
    chk("C_x0", 8'(xv), 8'b11);
    chk("C_rspv1", 8'(rsp_valid), 8'd1);
    chk("C_rspid1", 8'(rsp_id), 8'd1);
    chk("C_rspz1", 8'(rsp_z), 8'b10);
    val0 = 1'b0;
    tick; tick;
    chk("C_rspv0", 8'(rsp_valid), 8'd1);
    chk("C_rspid0", 8'(rsp_id), 8'd0);
    chk("C_rspz0", 8'(rsp_z), 8'b11);
    tick;

    // D: reset while responses are in flight
    val0 = 1'b1; sym0 = 2'b01; last0 = 1'b0;
    tick;
    chk("D_rdy0", 8'(rdy0), 8'd1);
    tick;
    chk("D_x", 8'(xv), 8'b01);
    val0 = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk_reset("D");
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("D_norsp", 8'(rsp_valid), 8'd0);
    end

    // E: granted requester stalls after one non-last symbol, requester 1 pending
    val0 = 1'b1; val1 = 1'b1; sym0 = 2'b10; last0 = 1'b0; last1 = 1'b0;
    tick;
    chk("E_rdy0", 8'(rdy0), 8'd1);
    tick;
    chk("E_x", 8'(xv), 8'b10);
    val0 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick;
      chk("E_stall_err", 8'(err), 8'd0);
      chk("E_stall_busy", 8'(busy), 8'd1);
      chk("E_stall_x", 8'(xv), 8'd0);
      chk("E_stall_rdy0", 8'(rdy0), 8'd1);
    end
    tick;
`ifdef SYM_SCHED_TIMEOUT_EN
    chk("E_to_err", 8'(err), 8'd1);
    chk("E_to_busy", 8'(busy), 8'd0);
    tick;
    chk("E_post_err", 8'(err), 8'd0);
    chk("E_post_busy", 8'(busy), 8'd1);
    chk("E_post_rdy1", 8'(rdy1), 8'd1);
`else
    chk("E_hold_err", 8'(err), 8'd0);
    chk("E_hold_busy", 8'(busy), 8'd1);
    tick;
    chk("E_hold_err2", 8'(err), 8'd0);
    chk("E_hold_busy2", 8'(busy), 8'd1);
    chk("E_hold_rdy0", 8'(rdy0), 8'd1);
    chk("E_hold_rdy1", 8'(rdy1), 8'd0);
`endif
    val0 = 1'b0; val1 = 1'b0;
    rst = 1'b1;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sym_sched.md
SYM_SCHED -- requirements
Module: sym_sched

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port val0  in  1  requester 0 symbol valid.
REQ-004 SHALL have port sym0  in  2  requester 0 symbol {x1,x0}.
REQ-005 SHALL have port last0  in  1  requester 0 final symbol of burst.
REQ-006 SHALL have port rdy0  out  1  requester 0 symbol accepted when val0&rdy0.
REQ-007 SHALL have ports val1, sym1, last1 and rdy1, identical to the requester 0 ports, for requester 1.
REQ-008 SHALL have port x1  out  1  FSM input x1, registered.
REQ-009 SHALL have port x0  out  1  FSM input x0, registered.
REQ-010 SHALL have port z_in  in  2  FSM outputs {z1,z0}.
REQ-011 SHALL have port rsp_valid  out  1  response strobe, one cycle per accepted symbol.
REQ-012 SHALL have port rsp_id  out  1  requester owning the response.
REQ-013 SHALL have port rsp_z  out  2  captured {z1,z0} for that symbol.
REQ-014 SHALL have port busy  out  1  high while in BURST.
REQ-015 SHALL have port err  out  1  one-cycle burst-timeout pulse (only when the timeout feature is compiled in).

Function
REQ-016 SHALL implement FSM states IDLE and BURST, plus a 1-bit gnt_id and a 1-bit last_gnt.
REQ-017 In IDLE with exactly one valN high, SHALL move to BURST with gnt_id=N at the next edge.
REQ-018 In IDLE with both valN high, SHALL grant the requester != last_gnt (round-robin).
REQ-019 SHALL drive rdyN = (state==BURST)&(gnt_id==N), combinationally from state; the ungranted rdy is 0.
REQ-020 On accept (valN&rdyN at edge k), SHALL register symN onto {x1,x0} for cycle k+1 only.
REQ-021 In any cycle without an accept at the preceding edge, SHALL drive {x1,x0}=00.
REQ-022 SHALL register z_in at edge k+2 into rsp_z, with rsp_valid=1 and rsp_id=gnt_id at accept time; latency from accept edge to rsp_valid is exactly 2 cycles.
REQ-023 SHALL carry rsp_id through a 2-stage valid/id pipeline, so responses remain correct across a grant change.
REQ-024 On accept with lastN=1, SHALL return to IDLE, set last_gnt=gnt_id and leave a minimum of one IDLE cycle between bursts.
REQ-025 A single-symbol burst (last=1 on first accept) SHALL be legal.
REQ-026 Changes in valN, symN or lastN of the ungranted requester during BURST SHALL have no effect.
REQ-027 A granted requester dropping val mid-burst SHALL hold the grant; no symbols are issued and x=00.
REQ-028 Throughput in BURST SHALL be one symbol per cycle.

Reset
REQ-029 On rst high, SHALL asynchronously force state=IDLE, gnt_id=0, last_gnt=1, x1=x0=0, rdy0=rdy1=0, rsp_valid=0, rsp_id=0, rsp_z=00, busy=0, err=0 and the timeout counter=0.
REQ-030 Reset mid-burst SHALL discard in-flight responses; no rsp_valid SHALL be issued for symbols accepted before reset.
REQ-031 After rst falls, requester 0 SHALL win the first simultaneous request.

Configuration
REQ-032 With macro SYM_SCHED_TIMEOUT_EN defined, SHALL keep a 3-bit counter of consecutive BURST cycles in which the granted val is low, cleared on any accept.
REQ-033 With SYM_SCHED_TIMEOUT_EN defined, when the counter reaches 7 and val is still low, SHALL return to IDLE at the next edge, set last_gnt=gnt_id and pulse err for one cycle.
REQ-034 Without SYM_SCHED_TIMEOUT_EN, SHALL omit the counter, tie err to 0 and hold the grant indefinitely.

Verification
REQ-035 Reset, then val0=1 with sym0=01, 10, 11 (last on 11) -> x sequence 01,10,11 on consecutive cycles; rsp_id=0 and rsp_valid on 3 consecutive cycles, each 2 cycles after its accept.
REQ-036 val0=val1=1 after reset, both sending single-symbol bursts, repeated -> grants 0,1,0,1 with one IDLE cycle between grants.
REQ-037 Burst from requester 1, then immediately from 0 -> final rsp of requester 1 carries rsp_id=1 even though gnt_id=0.
REQ-038 Assert rst two cycles after an accept -> no rsp_valid afterwards; all outputs at reset values.
REQ-039 With SYM_SCHED_TIMEOUT_EN defined: grant 0, accept one non-last symbol, drop val0 for 8 cycles -> err pulses once, busy falls, and pending val1 is granted next.
REQ-040 Without SYM_SCHED_TIMEOUT_EN: same stimulus as REQ-039 -> err stays 0 and busy stays 1.
